// File: rtl/midi_event_encoder.sv
// MIDI transmit framer: one event per handshake in, 1-3 bytes out to a byte-wide UART sender.
// Drops repeated channel status bytes (running status), forcing a resend after a long idle.
module midi_event_encoder #(
  parameter int RUNNING_STATUS_EN = 1,
  parameter int RS_REFRESH_CYCLES = 4800000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_event_valid,
  input  logic [7:0] midi_command,
  input  logic [6:0] midi_parameter_1,
  input  logic [6:0] midi_parameter_2,
  output logic       midi_event_ready,
  output logic [7:0] tx_data,
  output logic       tx_we,
  input  logic       tx_wait,
  output logic       busy
);

  localparam int CW_RAW = $clog2(RS_REFRESH_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] REFRESH_MAX = CW'(RS_REFRESH_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_STATUS, S_DATA1, S_DATA2} state_t;

  state_t        state, state_nx;
  logic [7:0]    cmd_r;
  logic [6:0]    p1_r, p2_r;
  logic [1:0]    len_r, len_in;
  logic [7:0]    last_status;
  logic [CW-1:0] rs_cnt;
  logic          accept, is_channel, refresh_expired, send_status;

  assign midi_event_ready = (state == S_IDLE);
  assign busy             = (state != S_IDLE);
  assign accept           = midi_event_valid && midi_event_ready;
  assign is_channel       = midi_command[7] && (midi_command[7:4] != 4'hF);
  assign refresh_expired  = (RS_REFRESH_CYCLES != 0) && (rs_cnt == REFRESH_MAX);
  assign send_status      = (RUNNING_STATUS_EN == 0) || (midi_command != last_status) ||
                            (last_status == 8'h00) || refresh_expired;

  always_comb begin
    case (midi_command[7:4])
      4'hC, 4'hD: len_in = 2'd1;
      4'hF:       len_in = 2'd0;
      default:    len_in = 2'd2;
    endcase
  end

  always_comb begin
    state_nx = state;
    tx_we    = 1'b0;
    tx_data  = 8'h00;
    case (state)
      S_IDLE: begin
        // Data bytes (cmd[7]==0) in the command slot are swallowed without output.
        if (accept && midi_command[7]) begin
          if (is_channel && !send_status) state_nx = S_DATA1;
          else                            state_nx = S_STATUS;
        end
      end
      S_STATUS: begin
        tx_we   = 1'b1;
        tx_data = cmd_r;
        if (!tx_wait) state_nx = (len_r == 2'd0) ? S_IDLE : S_DATA1;
      end
      S_DATA1: begin
        tx_we   = 1'b1;
        tx_data = {1'b0, p1_r};
        if (!tx_wait) state_nx = (len_r == 2'd1) ? S_IDLE : S_DATA2;
      end
      S_DATA2: begin
        tx_we   = 1'b1;
        tx_data = {1'b0, p2_r};
        if (!tx_wait) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cmd_r       <= 8'h00;
      p1_r        <= 7'h00;
      p2_r        <= 7'h00;
      len_r       <= 2'd0;
      last_status <= 8'h00;
      rs_cnt      <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cmd_r <= midi_command;
        p1_r  <= midi_parameter_1;
        p2_r  <= midi_parameter_2;
        len_r <= len_in;
        // System common clears running status; realtime leaves it untouched.
        if (is_channel)                                           last_status <= midi_command;
        else if (midi_command[7:3] == 5'b11110)                   last_status <= 8'h00;
      end
      if (state == S_STATUS && !tx_wait && cmd_r[7:4] != 4'hF)
        rs_cnt <= '0;
      else if (last_status != 8'h00 && rs_cnt != REFRESH_MAX)
        rs_cnt <= rs_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_midi_event_encoder.sv
// Scoreboard bench for midi_event_encoder: directed events push expected bytes, a monitor pops on each accepted byte.
module tb_midi_event_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       midi_event_valid = 1'b0;
  logic [7:0] midi_command = 8'h00;
  logic [6:0] midi_parameter_1 = 7'h00;
  logic [6:0] midi_parameter_2 = 7'h00;
  logic       midi_event_ready;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       tx_wait = 1'b0;
  logic       busy;

  logic [7:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  midi_event_encoder #(.RUNNING_STATUS_EN(1), .RS_REFRESH_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .midi_event_valid(midi_event_valid),
    .midi_command(midi_command), .midi_parameter_1(midi_parameter_1),
    .midi_parameter_2(midi_parameter_2), .midi_event_ready(midi_event_ready),
    .tx_data(tx_data), .tx_we(tx_we), .tx_wait(tx_wait), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic send(input logic [7:0] c, input logic [6:0] a, input logic [6:0] b);
    int n = 0;
    @(negedge clk);
    while (!midi_event_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!midi_event_ready) begin
      checks++;
      $display("FAIL ready_timeout: ready still low after %0d cycles, expected high", n);
    end
    midi_event_valid = 1'b1;
    midi_command     = c;
    midi_parameter_1 = a;
    midi_parameter_2 = b;
    @(negedge clk);
    midi_event_valid = 1'b0;
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: every byte the sender accepts must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && tx_we && !tx_wait) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte: got %02h, expected no byte", tx_data);
        end else begin
          chk("tx_byte", tx_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk("rst_tx_we", tx_we, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_ready", midi_event_ready, 1);
    rst_n = 1'b1;

    // 1: full message, three consecutive bytes with ready low
    push3(8'h90, 8'h3C, 8'h64);
    send(8'h90, 7'h3C, 7'h64);
    #2; chk("t1_b0", {tx_we, tx_data, midi_event_ready}, {1'b1, 8'h90, 1'b0});
    @(negedge clk); #2; chk("t1_b1", {tx_we, tx_data, midi_event_ready}, {1'b1, 8'h3C, 1'b0});
    @(negedge clk); #2; chk("t1_b2", {tx_we, tx_data, midi_event_ready}, {1'b1, 8'h64, 1'b0});
    @(negedge clk); #2; chk("t1_idle", {tx_we, midi_event_ready, busy}, {1'b0, 1'b1, 1'b0});

    // 2: running status, then a new status
    exp_q.push_back(8'h40); exp_q.push_back(8'h64);
    send(8'h90, 7'h40, 7'h64);
    push3(8'h80, 8'h3C, 8'h00);
    send(8'h80, 7'h3C, 7'h00);

    // 3: one-parameter messages
    exp_q.push_back(8'hC5); exp_q.push_back(8'h07);
    send(8'hC5, 7'h07, 7'h00);
    exp_q.push_back(8'h08);
    send(8'hC5, 7'h08, 7'h00);
    exp_q.push_back(8'hD0); exp_q.push_back(8'h10);
    send(8'hD0, 7'h10, 7'h00);
    send(8'h3C, 7'h11, 7'h22);
    #2; chk("invalid_cmd_idle", {busy, midi_event_ready, tx_we}, {1'b0, 1'b1, 1'b0});

    // 4: sender stall during DATA1 holds the byte
    push3(8'h90, 8'h3C, 8'h64);
    send(8'h90, 7'h3C, 7'h64);
    @(negedge clk);
    tx_wait = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2; chk("stall_hold", {tx_we, tx_data}, {1'b1, 8'h3C});
      @(negedge clk);
    end
    tx_wait = 1'b0;

    // 5: realtime keeps running status, system common clears it
    exp_q.push_back(8'hF0);
    send(8'hF0, 7'h00, 7'h00);
    push3(8'h90, 8'h3C, 8'h64);
    send(8'h90, 7'h3C, 7'h64);
    exp_q.push_back(8'hF8);
    send(8'hF8, 7'h00, 7'h00);
    exp_q.push_back(8'h3E); exp_q.push_back(8'h64);
    send(8'h90, 7'h3E, 7'h64);
    exp_q.push_back(8'hF6);
    send(8'hF6, 7'h00, 7'h00);
    push3(8'h90, 8'h40, 8'h64);
    send(8'h90, 7'h40, 7'h64);
    drain();

    // 6: refresh after long idle, then reset mid-message
    repeat (110) @(negedge clk);
    push3(8'h90, 8'h3C, 8'h64);
    send(8'h90, 7'h3C, 7'h64);
    push3(8'h80, 8'h3C, 8'h00);
    send(8'h80, 7'h3C, 7'h00);
    exp_q.push_back(8'h90);
    send(8'h90, 7'h3C, 7'h64);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #2; chk("reset_mid_msg", {tx_we, busy, midi_event_ready}, {1'b0, 1'b0, 1'b1});
    rst_n = 1'b1;
    push3(8'h90, 8'h3E, 8'h64);
    send(8'h90, 7'h3E, 7'h64);
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
